// File: rtl/window_pkg.sv
// Shared types and helpers for the window stream aligner.
// The struct below describes the default 640x480, 8-bit build.
package window_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_X_W       = $clog2(640);
  localparam int DEF_Y_W       = $clog2(480);

  typedef struct packed {
    logic signed [DEF_WORD_SIZE-1:0] pixel;
    logic [DEF_X_W-1:0]              x;
    logic [DEF_Y_W-1:0]              y;
    logic                            sof;
    logic                            eol;
    logic                            eof;
  } window_out_t;

  // Number of fully-inside window positions along an edge of the given width.
  function automatic int out_w(input int width, input int k);
    return width - k + 1;
  endfunction

endpackage

// File: rtl/window_stream_aligner_fifo.sv
// Synchronous FIFO with a combinational head; a push when full only lands
// if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Zero the head while empty so the outputs read 0 after reset.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/window_stream_aligner.sv
// Keeps results whose KxK window lies fully inside the image, tags them with
// output coordinates and frame markers, and queues them on a ready/valid stream.
module window_stream_aligner
  import window_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_WIDTH   = 640,
  parameter int NUM_ROWS    = 480,
  parameter int WORD_SIZE   = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          sof_in,
  input  logic signed [WORD_SIZE-1:0]   pixel_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WORD_SIZE-1:0]   out_pixel,
  output logic [$clog2(ROW_WIDTH)-1:0]  out_x,
  output logic [$clog2(NUM_ROWS)-1:0]   out_y,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic                          out_eof,
  output logic                          overflow
);

  localparam int X_W = $clog2(ROW_WIDTH);
  localparam int Y_W = $clog2(NUM_ROWS);

  if (out_w(ROW_WIDTH, KERNEL_SIZE) < 1 || out_w(NUM_ROWS, KERNEL_SIZE) < 1) begin : g_bad_kernel
    $error("KERNEL_SIZE must not exceed ROW_WIDTH or NUM_ROWS");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  // Entry layout follows the module parameters rather than the package defaults.
  typedef struct packed {
    logic signed [WORD_SIZE-1:0] pixel;
    logic [X_W-1:0]              x;
    logic [Y_W-1:0]              y;
    logic                        sof;
    logic                        eol;
    logic                        eof;
  } entry_t;

  logic [X_W-1:0] col, cur_col;
  logic [Y_W-1:0] row, cur_row;
  logic           keep, push, pop, drop, full, empty;
  entry_t         entry, head;

  // A sof beat is position (0,0) regardless of the running count.
  assign cur_col = sof_in ? '0 : col;
  assign cur_row = sof_in ? '0 : row;

  assign keep = in_valid && (cur_row >= Y_W'(KERNEL_SIZE - 1))
                         && (cur_col >= X_W'(KERNEL_SIZE - 1));

  always_comb begin
    entry       = '0;
    entry.pixel = pixel_in;
    entry.x     = cur_col - X_W'(KERNEL_SIZE - 1);
    entry.y     = cur_row - Y_W'(KERNEL_SIZE - 1);
    entry.sof   = (entry.x == '0) && (entry.y == '0);
    entry.eol   = (cur_col == X_W'(ROW_WIDTH - 1));
    entry.eof   = entry.eol && (cur_row == Y_W'(NUM_ROWS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (cur_col == X_W'(ROW_WIDTH - 1)) begin
        col <= '0;
        row <= (cur_row == Y_W'(NUM_ROWS - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  assign pop  = out_valid && out_ready;
  assign push = keep && (!full || pop);
  assign drop = keep && full && !pop;

  // A drop on the same beat as a resync still flags, so the loss is not hidden.
  always_ff @(posedge clk) begin
    if (reset)                   overflow <= 1'b0;
    else if (drop)               overflow <= 1'b1;
    else if (in_valid && sof_in) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_pixel = head.pixel;
  assign out_x     = head.x;
  assign out_y     = head.y;
  assign out_sof   = head.sof;
  assign out_eol   = head.eol;
  assign out_eof   = head.eof;

endmodule

// File: tb/tb_window_stream_aligner.sv
// Self-checking bench for window_stream_aligner on a 5x5 image, K=3, 4-deep FIFO.
module tb_window_stream_aligner;

  localparam int K  = 3;
  localparam int RW = 5;
  localparam int NR = 5;
  localparam int WS = 8;
  localparam int D  = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 sof_in = 1'b0;
  logic signed [WS-1:0] pixel_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [WS-1:0] out_pixel;
  logic [2:0]           out_x;
  logic [2:0]           out_y;
  logic                 out_sof, out_eol, out_eof, overflow;

  window_stream_aligner #(
    .KERNEL_SIZE (K), .ROW_WIDTH (RW), .NUM_ROWS (NR), .WORD_SIZE (WS), .FIFO_DEPTH (D)
  ) dut (
    .clk (clk), .reset (reset), .in_valid (in_valid), .sof_in (sof_in),
    .pixel_in (pixel_in), .out_valid (out_valid), .out_ready (out_ready),
    .out_pixel (out_pixel), .out_x (out_x), .out_y (out_y), .out_sof (out_sof),
    .out_eol (out_eol), .out_eof (out_eof), .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WS-1:0] pixel;
    int            x;
    int            y;
    bit            sof;
    bit            eol;
    bit            eof;
  } exp_t;

  exp_t exp_tab [9];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic compare_head(input string tag, input exp_t e);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".pixel"}, {24'd0, out_pixel}, {24'd0, e.pixel});
    check({tag, ".x"},     32'(out_x), e.x);
    check({tag, ".y"},     32'(out_y), e.y);
    check({tag, ".sof"},   32'(out_sof), 32'(e.sof));
    check({tag, ".eol"},   32'(out_eol), 32'(e.eol));
    check({tag, ".eof"},   32'(out_eof), 32'(e.eof));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    sof_in   = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
  endtask

  task automatic beat(input logic [WS-1:0] v, input bit s);
    in_valid = 1'b1;
    sof_in   = s;
    pixel_in = v;
    step();
    in_valid = 1'b0;
    sof_in   = 1'b0;
  endtask

  // Feeds 1..25 with out_ready=1 and compares every emitted result with the table.
  task automatic run_frame(input string tag, input bit gapped, input bit sof_first);
    int k = 0;
    out_ready = 1'b1;
    for (int v = 1; v <= 25; v++) begin
      beat(WS'(v), sof_first && (v == 1));
      if (out_valid) begin
        if (k < 9) compare_head($sformatf("%s[%0d]", tag, k), exp_tab[k]);
        else       check({tag, ".extra"}, 32'(out_pixel), 32'd0);
        k++;
      end
      if (gapped) begin
        step();
        check({tag, ".gap_idle"}, 32'(out_valid), 32'd0);
      end
    end
    step();
    check({tag, ".count"}, k, 9);
    check({tag, ".overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic drain(input string tag, input int first, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      compare_head($sformatf("%s[%0d]", tag, i), exp_tab[first + i]);
      step();
    end
    check({tag, ".empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    exp_tab[0] = '{8'd13, 0, 0, 1'b1, 1'b0, 1'b0};
    exp_tab[1] = '{8'd14, 1, 0, 1'b0, 1'b0, 1'b0};
    exp_tab[2] = '{8'd15, 2, 0, 1'b0, 1'b1, 1'b0};
    exp_tab[3] = '{8'd18, 0, 1, 1'b0, 1'b0, 1'b0};
    exp_tab[4] = '{8'd19, 1, 1, 1'b0, 1'b0, 1'b0};
    exp_tab[5] = '{8'd20, 2, 1, 1'b0, 1'b1, 1'b0};
    exp_tab[6] = '{8'd23, 0, 2, 1'b0, 1'b0, 1'b0};
    exp_tab[7] = '{8'd24, 1, 2, 1'b0, 1'b0, 1'b0};
    exp_tab[8] = '{8'd25, 2, 2, 1'b0, 1'b1, 1'b1};

    step();
    do_reset();
    check("reset.valid",    32'(out_valid), 32'd0);
    check("reset.overflow", 32'(overflow),  32'd0);
    check("reset.pixel",    {24'd0, out_pixel}, 32'd0);
    check("reset.xy",       {26'd0, out_x, out_y}, 32'd0);
    check("reset.flags",    {29'd0, out_sof, out_eol, out_eof}, 32'd0);

    run_frame("basic", 1'b0, 1'b0);

    // Backpressure: 13,14,15,18 fill the FIFO, 19 is dropped.
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 25; v++) begin
      beat(WS'(v), 1'b0);
      if (v == 18) check("bp.ovf_before", 32'(overflow), 32'd0);
      if (v == 19) check("bp.ovf_set",    32'(overflow), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      compare_head($sformatf("bp.stall%0d", i), exp_tab[0]);
      step();
    end
    drain("bp.drain", 0, 4);
    check("bp.ovf_sticky", 32'(overflow), 32'd1);

    // Resync: 6 stray beats, then sof_in restarts the count and clears overflow.
    for (int v = 0; v < 6; v++) beat(WS'(100 + v), 1'b0);
    run_frame("resync", 1'b0, 1'b1);

    // Full with a simultaneous pop: 19 replaces 13, no overflow.
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 18; v++) beat(WS'(v), 1'b0);
    compare_head("fullpop.pre", exp_tab[0]);
    out_ready = 1'b1;
    beat(8'd19, 1'b0);
    out_ready = 1'b0;
    check("fullpop.ovf", 32'(overflow), 32'd0);
    drain("fullpop.drain", 1, 4);

    run_frame("gapped", 1'b1, 1'b1);

    // Reset mid-frame with 14 and 15 queued.
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 13; v++) beat(WS'(v), 1'b0);
    out_ready = 1'b1;
    beat(8'd14, 1'b0);
    out_ready = 1'b0;
    beat(8'd15, 1'b0);
    compare_head("midrst.queued", exp_tab[1]);
    do_reset();
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.pixel", {24'd0, out_pixel}, 32'd0);
    run_frame("midrst.frame", 1'b0, 1'b0);

    // Two frames back to back without sof_in.
    begin
      int k = 0;
      do_reset();
      out_ready = 1'b1;
      for (int f = 0; f < 2; f++) begin
        for (int v = 1; v <= 25; v++) begin
          beat(WS'(v), 1'b0);
          if (out_valid) begin
            compare_head($sformatf("multi[%0d]", k), exp_tab[k % 9]);
            k++;
          end
        end
      end
      check("multi.count", k, 18);
    end

    // Random traffic against a position/queue reference model.
    begin
      exp_t q[$];
      int   pos  = 0;
      bit   movf = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
        bit            iv, sf, rdy, keep, pop;
        logic [WS-1:0] pix;
        int            r, c;
        exp_t          e;
        iv  = ($urandom_range(0, 3) != 0);
        sf  = ($urandom_range(0, 29) == 0);
        rdy = ($urandom_range(0, 2) != 0);
        pix = WS'($urandom);
        in_valid = iv; sof_in = sf; pixel_in = pix; out_ready = rdy;

        check("rand.valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0 && out_valid) compare_head("rand", q[0]);
        check("rand.overflow", 32'(overflow), 32'(movf));

        keep = 1'b0;
        pop  = (q.size() > 0) && rdy;
        if (iv) begin
          if (sf) begin
            pos  = 0;
            movf = 1'b0;
          end
          r = pos / RW;
          c = pos % RW;
          keep = (r >= K - 1) && (c >= K - 1);
          e = '{pix, c - (K - 1), r - (K - 1), (r == K - 1) && (c == K - 1),
                c == RW - 1, (c == RW - 1) && (r == NR - 1)};
          pos = (pos + 1) % (RW * NR);
        end
        if (pop) void'(q.pop_front());
        if (keep) begin
          if (q.size() < D) q.push_back(e);
          else              movf = 1'b1;
        end
        step();
      end
      in_valid = 1'b0;
      sof_in   = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/window_stream_aligner.md
Name: window_stream_aligner

Overview:
- Sits downstream of the sliding-window and kernel datapath. It takes the per-clock filtered result stream and keeps only the results whose KxK window lies fully inside the image. Results from warm-up rows and from windows that wrap across a row are discarded.
- It tags each kept result with output coordinates and frame markers, then presents it on a ready/valid stream through an internal FIFO. This lets the downstream consumer (frame writer, VGA buffer) apply backpressure while the upstream side never stalls.

Parameters:
- KERNEL_SIZE, 3, window edge length K.
- ROW_WIDTH, 640, input pixels per row.
- NUM_ROWS, 480, input rows per frame.
- WORD_SIZE, 8, result width in bits, signed.
- FIFO_DEPTH, 16, output FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all logic is on the posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  the result on pixel_in is valid this cycle. Each valid beat corresponds to one input pixel, in raster order.
- sof_in  in  1  qualified by in_valid; marks this beat as input pixel (row 0, col 0).
- pixel_in  in  WORD_SIZE  signed filtered result. Its window's bottom-right pixel is the current input position.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_pixel  out  WORD_SIZE  signed result.
- out_x  out  $clog2(ROW_WIDTH)  output column, 0..ROW_WIDTH-K.
- out_y  out  $clog2(NUM_ROWS)  output row, 0..NUM_ROWS-K.
- out_sof  out  1  first kept result of a frame.
- out_eol  out  1  last kept result of an output row.
- out_eof  out  1  last kept result of a frame.
- overflow  out  1  sticky; set when a kept result is dropped.

Behaviour:
- Reset (synchronous, active-high):
  - col and row counters go to 0.
  - FIFO is emptied.
  - out_valid=0, overflow=0.
  - out_pixel, out_x, out_y, out_sof, out_eol and out_eof go to 0.
  - Reset in mid-frame discards all FIFO contents. The next valid beat counts as (0,0) whether or not sof_in is set.
- Position counters:
  - Advance only on in_valid. col counts 0..ROW_WIDTH-1.
  - When col wraps, row increments. When row wraps past NUM_ROWS-1, it returns to 0, and the next beat is the next frame.
  - When in_valid && sof_in, the current beat is taken as (0,0), and the counters become col=1, row=0 for the next beat. This resync overrides any count in progress.
- Keep rule:
  - A beat at input position (r,c) is kept iff r>=K-1 and c>=K-1.
  - out_x = c-(K-1); out_y = r-(K-1).
  - Marker flags on a kept beat:
    - sof: out_x==0 && out_y==0.
    - eol: c==ROW_WIDTH-1.
    - eof: eol && r==NUM_ROWS-1.
- Push latency:
  - A kept beat is written to the FIFO at the clock edge of its in_valid cycle.
  - out_valid rises on the next cycle if the FIFO was empty. Input-to-output latency is 1 clock with no bypass.
- FIFO and handshake:
  - Entry contents: {pixel, x, y, sof, eol, eof}.
  - The head is presented combinationally from the FIFO storage.
  - Pop occurs iff out_valid && out_ready.
  - Output fields hold stable while out_valid && !out_ready.
- Full boundary:
  - A push when full is accepted only if a pop happens in the same cycle, so occupancy stays at FIFO_DEPTH.
  - Otherwise the beat is dropped and overflow is set to 1.
  - overflow clears only on reset or on an in_valid && sof_in beat.
- Empty boundary: a pop is impossible when empty. Simultaneous push and pop when empty gives occupancy 1 next cycle.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. An occupancy counter of width $clog2(FIFO_DEPTH)+1 tracks the fill level.
- Parameter checks (elaboration-time): K<=ROW_WIDTH and K<=NUM_ROWS.

Decomposition:
- Package window_pkg:
  - typedef window_out_t, a packed struct {pixel, x, y, sof, eol, eof}, parameterised through localparam widths.
  - Function out_w(width,k) returning width-k+1.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Same clk/reset convention as this block.
- The aligner top holds only the counters, keep logic, overflow flag and FIFO instance.

Test Plan:
- Basic frame: K=3, ROW_WIDTH=5, NUM_ROWS=5, FIFO_DEPTH=4, out_ready=1, feed 1..25 on consecutive cycles.
  - Exactly 9 outputs: 13,14,15,18,19,20,23,24,25.
  - (x,y) run from (0,0) to (2,2).
  - sof on 13; eol on 15,20,25; eof on 25 only; overflow stays 0.
- Backpressure: same stimulus with out_ready=0 throughout.
  - FIFO holds 13,14,15,18; 19 is dropped and overflow=1.
  - Raising out_ready then drains exactly 13,14,15,18 in order, with fields stable while stalled.
- Full with simultaneous pop: FIFO full, out_ready=1 on the cycle 19 arrives.
  - 13 pops, 19 is accepted, occupancy stays 4, overflow stays 0.
- Gapped input and resync:
  - in_valid toggles 1/0 across the frame; outputs are identical to the basic frame.
  - sof_in asserted on the 7th beat restarts counting at that beat: the first output is the 13th beat after resync, and overflow clears.
- Reset mid-frame: assert reset after 15 input beats with 2 entries queued.
  - Next cycle out_valid=0 and the FIFO is empty.
  - Feeding 1..25 afterwards reproduces the basic-frame output exactly.
- Multi-frame wrap: feed 50 beats (values 1..25 twice) with no sof_in.
  - 18 outputs; the second frame repeats the first frame's coordinates and flags.
